// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: multiplexed 8-digit hex display scanner with a four-phase digit-write port.
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      asynchronous active-high reset
//   wr_req_i   digit-write request (four-phase handshake)
//   wr_idx_i   target digit 0..7
//   wr_data_i  hex value to store
//   wr_ack_o   one-cycle write acknowledge
//   en_i       per-digit enable mask
//   an_o       active-low anode selects
//   seg_o      active-low segments {g,f,e,d,c,b,a}
//   frame_o    one-cycle pulse when the scan wraps from digit 7 to digit 0
// Optional build macro LZ_BLANK_EN: blank leading-zero digits (digit 0 always shown).
module hex_scan_ctrl #(
    parameter int DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_req_i,
    input  logic [2:0] wr_idx_i,
    input  logic [3:0] wr_data_i,
    output logic       wr_ack_o,
    input  logic [7:0] en_i,
    output logic [7:0] an_o,
    output logic [6:0] seg_o,
    output logic       frame_o
);
    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;
    localparam logic [15:0] LAST = 16'(DIV - 1);
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [3:0]  regs [8];
    logic        wrap;
    logic        wr_en;
    logic        show;
    assign wrap = cnt == LAST;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt     <= '0;
            idx     <= '0;
            frame_o <= 1'b0;
        end else begin
            cnt     <= wrap ? '0 : cnt + 16'd1;
            idx     <= wrap ? idx + 3'd1 : idx;
            frame_o <= wrap && idx == 3'd7;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_idx_i] <= wr_data_i;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_ack_o  = 1'b0;
        case (state)
            IDLE: begin
                wr_en     = wr_req_i;
                state_nxt = wr_req_i ? ACK : IDLE;
            end
            ACK: begin
                wr_ack_o  = 1'b1;
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: state_nxt = wr_req_i ? WAIT_LOW : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end
`ifdef LZ_BLANK_EN
    // tail[n] is set when any of regs[n..7] is non-zero
    logic [7:0] tail;
    logic       acc;
    always_comb begin
        acc  = 1'b0;
        tail = '0;
        for (int n = 7; n >= 0; n--) begin
            acc     = acc | (regs[n] != 4'd0);
            tail[n] = acc;
        end
    end
    assign show = en_i[idx] && (idx == 3'd0 || tail[idx]);
`else
    assign show = en_i[idx];
`endif
    // cnt==0 is the guard cycle: everything dark while the anode switches
    assign an_o  = (cnt != '0 && show) ? ~(8'b1 << idx) : 8'hFF;
    assign seg_o = (cnt != '0) ? SEG_LUT[regs[idx]] : 7'h7F;
endmodule
